// File: rtl/fip_32_to_float.sv
// fip_32_to_float
// Three-stage pipelined converter from signed Q16.16 fixed point to IEEE-754
// single precision, with valid/ready flow control on both sides.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   in_valid     input word present
//   in_ready     converter can accept an input this cycle (1 while in reset)
//   in_data      signed fixed-point operand (FRAC_BITS fractional bits)
//   out_valid    result present
//   out_ready    downstream accepts the result this cycle
//   out_data     IEEE-754 single {sign, exp[7:0], frac[22:0]}
//   out_inexact  rounding discarded nonzero bits for this result
//
// Stage 1 takes the absolute value, stage 2 counts leading zeros, and stage 3
// normalizes, rounds to nearest-even and packs. Stage 3 is the output register.
module fip_32_to_float #(
  parameter int FRAC_BITS   = 16,
  parameter int PIPE_STAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  // Exponent of a value whose MSB sits at bit 31 of the magnitude.
  localparam logic [7:0] EXP_BASE = 8'(127 + 31 - FRAC_BITS);

  if (PIPE_STAGES != 3) begin : g_bad_pipe_stages
    $error("fip_32_to_float: PIPE_STAGES must be 3");
  end

  // Leading-zero count of a 32-bit word; returns 0 for an all-zero word,
  // which stage 3 never uses because zero takes its own path.
  function automatic logic [4:0] clz32(input logic [31:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (found) begin
        n = n;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        n = n + 5'd1;
      end
    end
    return n;
  endfunction

  logic        adv1, adv2, adv3;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q,  s1_sign_d;
  logic [31:0] s1_mag_q,   s1_mag_d;

  logic        s2_valid_q, s2_valid_d;
  logic        s2_sign_q,  s2_sign_d;
  logic [31:0] s2_mag_q,   s2_mag_d;
  logic [4:0]  s2_lz_q,    s2_lz_d;
  logic        s2_zero_q,  s2_zero_d;

  logic        s3_valid_q,   s3_valid_d;
  logic [31:0] s3_data_q,    s3_data_d;
  logic        s3_inexact_q, s3_inexact_d;

  logic [31:0] norm_s;
  logic        guard_s, sticky_s, round_up_s;
  logic [24:0] rounded_s;
  logic [7:0]  exp_s;
  logic [22:0] frac_s;

  // Pipeline advance chain: a stage may load when its successor is empty or moving.
  always_comb begin
    adv3 = !s3_valid_q | out_ready;
    adv2 = !s2_valid_q | adv3;
    adv1 = !s1_valid_q | adv2;
  end

  assign in_ready    = adv1 | reset;
  assign out_valid   = s3_valid_q;
  assign out_data    = s3_data_q;
  assign out_inexact = s3_inexact_q;

  // Stage 1: sign and absolute value. 0x80000000 negates to itself, which as
  // an unsigned magnitude is exactly 2^31.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      s1_sign_d  = in_data[31];
      s1_mag_d   = in_data[31] ? (~in_data + 32'd1) : in_data;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: leading-zero count and zero detect.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_mag_d   = s2_mag_q;
    s2_lz_d    = s2_lz_q;
    s2_zero_d  = s2_zero_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_mag_d   = s1_mag_q;
      s2_lz_d    = clz32(s1_mag_q);
      s2_zero_d  = (s1_mag_q == 32'd0);
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Stage 3: normalize, round to nearest-even, pack. A carry out of the
  // 24-bit mantissa leaves 1.000... so the fraction is zero and exp bumps.
  always_comb begin
    norm_s     = s2_mag_q << s2_lz_q;
    guard_s    = norm_s[7];
    sticky_s   = |norm_s[6:0];
    round_up_s = guard_s & (sticky_s | norm_s[8]);
    rounded_s  = {1'b0, norm_s[31:8]} + {24'd0, round_up_s};
    exp_s      = EXP_BASE - {3'b000, s2_lz_q} + {7'd0, rounded_s[24]};
    frac_s     = rounded_s[24] ? rounded_s[23:1] : rounded_s[22:0];

    s3_valid_d   = s3_valid_q;
    s3_data_d    = s3_data_q;
    s3_inexact_d = s3_inexact_q;
    if (adv3) begin
      s3_valid_d = s2_valid_q;
      if (!s2_valid_q) begin
        s3_data_d    = s3_data_q;
        s3_inexact_d = s3_inexact_q;
      end else if (s2_zero_q) begin
        s3_data_d    = 32'h0000_0000;
        s3_inexact_d = 1'b0;
      end else begin
        s3_data_d    = {s2_sign_q, exp_s, frac_s};
        s3_inexact_d = guard_s | sticky_s;
      end
    end else begin
      s3_valid_d = s3_valid_q;
    end
  end

  // Pipeline registers with synchronous reset that discards all in-flight words.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_mag_q     <= 32'd0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_mag_q     <= 32'd0;
      s2_lz_q      <= 5'd0;
      s2_zero_q    <= 1'b0;
      s3_valid_q   <= 1'b0;
      s3_data_q    <= 32'd0;
      s3_inexact_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_mag_q     <= s1_mag_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_mag_q     <= s2_mag_d;
      s2_lz_q      <= s2_lz_d;
      s2_zero_q    <= s2_zero_d;
      s3_valid_q   <= s3_valid_d;
      s3_data_q    <= s3_data_d;
      s3_inexact_q <= s3_inexact_d;
    end
  end

endmodule

// File: doc/fip_32_to_float.md
Name: fip_32_to_float

Overview:
- Pipelined converter from signed Q16.16 fixed-point to IEEE-754 single-precision float. It runs in the opposite direction to the existing fixed-point datapath.
- It sits at the boundary where Q16.16 results from the fip_32 adder/sub/mult/div units leave the raytracing core for float consumers (host readback, debug export).
- Valid/ready on both sides; throughput 1 conversion/cycle; latency 3 cycles.

Parameters:
- FRAC_BITS, 16, number of fractional bits in the input format. Exponent bias offset = 127 + 31 - FRAC_BITS.
- PIPE_STAGES, 3, fixed at 3; any other value is a synthesis error.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  converter can accept input this cycle
- in_data  in  32  signed Q16.16 operand
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result this cycle
- out_data  out  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}
- out_inexact  out  1  rounding discarded nonzero bits for this result

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, ports clk/reset.
- Reset values: s1/s2/s3 valid = 0, out_valid = 0, out_data = 0, out_inexact = 0.
- in_ready is combinational from state and out_ready; it is 1 during reset.
- Reset mid-operation discards all in-flight data; no partial result is emitted.
- Handshake:
  - Transfer occurs when valid && ready on a side.
  - Stage k loads when its successor is empty or advancing. adv3 = !s3_valid | out_ready; adv2 = !s2_valid | adv3; adv1 = !s1_valid | adv2; in_ready = adv1.
  - out_valid, out_data and out_inexact are stable while out_valid && !out_ready.
  - No bubbles are inserted; a full pipeline with out_ready held high moves 1 word/cycle.
- Stage 1: sign = in_data[31]; mag = 33-bit-safe two's-complement absolute value as unsigned 32. 0x80000000 gives mag = 2^31.
- Stage 2: lz = leading-zero count of mag (0..31); zero = (mag == 0).
- Stage 3, normalize, round and pack:
  - norm = mag << lz (bit 31 = 1).
  - Keep norm[31:8] (24 bits): guard = norm[7], sticky = |norm[6:0].
  - Round-to-nearest-even: increment when guard && (sticky || norm[8]).
  - Mantissa carry-out (all ones + 1): mantissa = 0x800000 and exponent + 1.
  - exp = 142 - lz (FRAC_BITS = 16), +1 on carry. Range 111..143, so there is no overflow, denormal or infinity path.
  - frac = rounded[22:0].
  - out_inexact = guard | sticky.
  - zero: out_data = 0x00000000 (always +0), out_inexact = 0.
- Latency: a word accepted at edge N is presented with out_valid = 1 after edge N+3, with no stalls.
- Boundary conditions:
  - Back-to-back inputs with out_ready low for M cycles: the pipeline fills 3 deep, then in_ready = 0. No word is dropped or duplicated. Order is preserved.
  - Simultaneous accept at both ends when full: supported, and occupancy is unchanged.

Test Plan:
- Basic conversions, one at a time with out_ready = 1:
  - 0x00010000 → 0x3F800000
  - 0xFFFF0000 → 0xBF800000
  - 0x00008000 → 0x3F000000
  - 0x00000001 → 0x37800000
  - 0x00000000 → 0x00000000
  - all with inexact = 0; each out_valid exactly 3 cycles after acceptance.
- Extremes:
  - 0x80000000 → 0xC7000000, inexact 0
  - 0x7FFFFFFF → 0x47000000 (rounding carry into exponent), inexact 1
- Ties to even:
  - 0x01000001 → 0x43800000, inexact 1
  - 0x01000003 → 0x43800002, inexact 1
- Backpressure: stream 8 words with in_valid = 1 and out_ready held 0 for 10 cycles.
  - in_ready must drop after exactly 3 accepts.
  - Outputs stay stable while stalled.
  - After release, all 8 results emerge in order, 1 per cycle, none lost.
- Random throttling: 1000 random in_data values with random in_valid/out_ready. Results must match a reference model (real'(x)/65536 → $shortrealtobits) bit-exactly, with matching inexact.
- Reset mid-stream: assert reset for 1 cycle with 3 words in flight.
  - Next cycle out_valid = 0 and out_data = 0.
  - No stale results appear afterward.
  - A new input 0x00020000 yields 0x40000000 three cycles later.
